// File: rtl/rsa_pkg.sv
// Shared types and constants for the DMA request scheduler.
// Holds the FSM encoding, address width, default data width and a ring-index helper.
package rsa_pkg;

   localparam int ADDR_W     = 32;
   localparam int DEF_DATA_W = 1024;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_RESP      = 2'd3
   } state_t;

   // Slot 'ofs' positions after 'base' on a ring of n requesters.
   function automatic int rr_slot(input int base, input int ofs, input int n);
      int s;
      s = base + ofs;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: first active request at or after ptr wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
   import rsa_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      int c;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int i = 0; i < NREQ; i++) begin
         c = rr_slot(int'(ptr), i, NREQ);
         if (!any && req[c]) begin
            any      = 1'b1;
            grant[c] = 1'b1;
            idx      = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/dma_scheduler.sv
// Shares one DMA engine between NREQ requesters, one transfer at a time.
// Grants round-robin, launches the transfer, watches for done/error/timeout, then pulses a response.
//
//  state       | meaning
//  S_IDLE      | waiting for any req_valid; grant is combinational here
//  S_START     | holding the direction's start until the engine leaves idle
//  S_WAIT_DONE | engine running; waiting for dma_done or timeout
//  S_RESP      | one-cycle rsp_valid pulse to the granted requester
module dma_scheduler
   import rsa_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          rsp_valid,
   output logic                     rsp_error,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic [ADDR_W-1:0]        dma_rx_address,
   output logic [ADDR_W-1:0]        dma_tx_address,
   output logic [DATA_W-1:0]        dma_tx_data,
   output logic                     dma_rx_start,
   output logic                     dma_tx_start,
   input  logic [DATA_W-1:0]        dma_rx_data,
   input  logic                     dma_done,
   input  logic                     dma_idle,
   input  logic                     dma_error,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  cur_id
);

   localparam int IDX_W = $clog2(NREQ);

   state_t              state, state_nx;
   logic [IDX_W-1:0]    ptr;
   logic [IDX_W-1:0]    id_q;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [CNT_W-1:0]    cnt;
   logic                err_q;

   logic [NREQ-1:0]     grant;
   logic [IDX_W-1:0]    gidx;
   logic                gany;
   logic                grant_en;
   logic                running;
   logic                tmo;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   assign grant_en = (state == S_IDLE) && gany;
   assign running  = (state == S_START) || (state == S_WAIT_DONE);
   assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // In S_WAIT_DONE a completion beats a coincident timeout.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (gany) state_nx = S_START;
         S_START:     if (tmo) state_nx = S_RESP;
                      else if (!dma_idle) state_nx = S_WAIT_DONE;
         S_WAIT_DONE: if (dma_done || tmo) state_nx = S_RESP;
         S_RESP:      state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         id_q    <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt     <= '0;
         err_q   <= 1'b0;
      end else begin
         if (grant_en) begin
            ptr     <= IDX_W'(rr_slot(int'(gidx), 1, NREQ));
            id_q    <= gidx;
            wr_q    <= req_write[gidx];
            addr_q  <= req_addr[int'(gidx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(gidx)*DATA_W +: DATA_W];
            cnt     <= '0;
            err_q   <= 1'b0;
         end else if (running) begin
            cnt <= cnt + 1'b1;
            if (dma_error)
               err_q <= 1'b1;
            else if (tmo && !((state == S_WAIT_DONE) && dma_done))
               err_q <= 1'b1;
         end
         if ((state == S_WAIT_DONE) && dma_done && !wr_q)
            rdata_q <= dma_rx_data;
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state == S_IDLE) req_ready = grant;
      if (state == S_RESP) rsp_valid[id_q] = 1'b1;
   end

   assign rsp_error      = (state == S_RESP) && err_q;
   assign rsp_rdata      = rdata_q;
   assign dma_rx_address = addr_q;
   assign dma_tx_address = addr_q;
   assign dma_tx_data    = wdata_q;
   assign dma_rx_start   = (state == S_START) && !wr_q;
   assign dma_tx_start   = (state == S_START) && wr_q;
   assign busy           = (state != S_IDLE);
   assign cur_id         = id_q;

endmodule

// File: tb/tb_dma_scheduler.sv
// Directed bench for dma_scheduler with a scripted DMA engine.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_dma_scheduler;

   localparam int NREQ    = 4;
   localparam int DATA_W  = 1024;
   localparam int TIMEOUT = 16;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_write;
   logic [NREQ*32-1:0]       req_addr;
   logic [NREQ*DATA_W-1:0]   req_wdata;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ-1:0]          rsp_valid;
   logic                     rsp_error;
   logic [DATA_W-1:0]        rsp_rdata;
   logic [31:0]              dma_rx_address;
   logic [31:0]              dma_tx_address;
   logic [DATA_W-1:0]        dma_tx_data;
   logic                     dma_rx_start;
   logic                     dma_tx_start;
   logic [DATA_W-1:0]        dma_rx_data;
   logic                     dma_done;
   logic                     dma_idle;
   logic                     dma_error;
   logic                     busy;
   logic [1:0]               cur_id;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0]       exp_addr [NREQ];
   logic [DATA_W-1:0] exp_wd   [NREQ];
   logic [DATA_W-1:0] pat_a5;
   logic [DATA_W-1:0] pat_5a;
   logic [DATA_W-1:0] pat_c3;

   always #5 clk = ~clk;

   dma_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_error      (rsp_error),
      .rsp_rdata      (rsp_rdata),
      .dma_rx_address (dma_rx_address),
      .dma_tx_address (dma_tx_address),
      .dma_tx_data    (dma_tx_data),
      .dma_rx_start   (dma_rx_start),
      .dma_tx_start   (dma_tx_start),
      .dma_rx_data    (dma_rx_data),
      .dma_done       (dma_done),
      .dma_idle       (dma_idle),
      .dma_error      (dma_error),
      .busy           (busy),
      .cur_id         (cur_id)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // Engine model: leaves idle in the first start cycle, raises done/error on scripted
   // cycle offsets (offset 0 = first S_START cycle). Records what the scheduler shows.
   task automatic run_xfer(input bit keep, input int done_after, input int err_at,
                           input logic [DATA_W-1:0] rdata, input logic [31:0] e_addr,
                           input logic [DATA_W-1:0] e_wd,
                           output int gid, output int n_rx, output int n_tx, output int n_rsp,
                           output int rsp_cyc, output logic [NREQ-1:0] rsp_vec,
                           output logic rsp_err, output int stab_bad, output bit timed_out);
      int c;
      c = -1; gid = -1; n_rx = 0; n_tx = 0; n_rsp = 0; rsp_cyc = -1;
      rsp_vec = '0; rsp_err = 1'b0; stab_bad = 0; timed_out = 1'b1;
      for (int k = 0; k < 80; k++) begin
         cyc();
         if (c < 0 && (dma_rx_start || dma_tx_start)) begin
            c = 0;
            gid = int'(cur_id);
            if (!keep) req_valid = '0;
         end else if (c >= 0) begin
            c++;
         end
         if (c >= 0) begin
            n_rx += int'(dma_rx_start);
            n_tx += int'(dma_tx_start);
            if (n_rsp == 0 && (dma_tx_address !== e_addr || dma_rx_address !== e_addr ||
                               dma_tx_data !== e_wd))
               stab_bad++;
            if (rsp_valid != '0) begin
               n_rsp++;
               rsp_cyc = c;
               rsp_vec = rsp_valid;
               rsp_err = rsp_error;
            end
            if (!busy) begin
               timed_out = 1'b0;
               dma_idle = 1'b1; dma_done = 1'b0; dma_error = 1'b0;
               break;
            end
            dma_idle  = 1'b0;
            dma_done  = (c == done_after);
            dma_error = (c == err_at);
            if (c == done_after) dma_rx_data = rdata;
         end
      end
      dma_idle = 1'b1; dma_done = 1'b0; dma_error = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want 0000", req_ready); end
      n_vec++; if (rsp_valid !== 4'b0000 || rsp_error !== 1'b0) begin n_err++; $display("FAIL reset_rsp got %b/%b want 0000/0", rsp_valid, rsp_error); end
      n_vec++; if (dma_rx_start !== 1'b0 || dma_tx_start !== 1'b0) begin n_err++; $display("FAIL reset_start got %b%b want 00", dma_rx_start, dma_tx_start); end
      n_vec++; if (cur_id !== 2'd0) begin n_err++; $display("FAIL reset_cur_id got %0d want 0", cur_id); end
      n_vec++; if (rsp_rdata !== '0 || dma_tx_data !== '0 || dma_tx_address !== 32'h0 || dma_rx_address !== 32'h0) begin
         n_err++; $display("FAIL reset_latches got addr %h want 0", dma_tx_address); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_single_rx();
      int gid, n_rx, n_tx, n_rsp, rc, sb; logic [NREQ-1:0] rv; logic re; bit to;
      req_write = 4'b0000;
      req_valid = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rx_ready got %b want 0100", req_ready); end
      run_xfer(1'b0, 10, -1, pat_a5, exp_addr[2], exp_wd[2], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL rx_bound got expired want done"); end
      n_vec++; if (gid !== 2) begin n_err++; $display("FAIL rx_grant got %0d want 2", gid); end
      n_vec++; if (n_rx !== 1 || n_tx !== 0) begin n_err++; $display("FAIL rx_starts got rx=%0d tx=%0d want 1/0", n_rx, n_tx); end
      n_vec++; if (n_rsp !== 1 || rv !== 4'b0100) begin n_err++; $display("FAIL rx_rsp got n=%0d vec=%b want 1/0100", n_rsp, rv); end
      n_vec++; if (rc !== 11) begin n_err++; $display("FAIL rx_latency got %0d want 11", rc); end
      n_vec++; if (re !== 1'b0) begin n_err++; $display("FAIL rx_error got %0b want 0", re); end
      n_vec++; if (rsp_rdata !== pat_a5) begin n_err++; $display("FAIL rx_rdata got %h want a5 pattern", rsp_rdata[31:0]); end
      n_vec++; if (sb !== 0) begin n_err++; $display("FAIL rx_addr_stable got %0d bad cycles want 0", sb); end
   endtask

   task automatic test_tx();
      int gid, n_rx, n_tx, n_rsp, rc, sb; logic [NREQ-1:0] rv; logic re; bit to;
      logic [DATA_W-1:0] junk;
      junk = {32{32'hDEAD_BEEF}};
      req_write = 4'b0010;
      req_valid = 4'b0010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL tx_ready got %b want 0010", req_ready); end
      run_xfer(1'b0, 5, -1, junk, exp_addr[1], exp_wd[1], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
      n_vec++; if (to !== 1'b0 || gid !== 1) begin n_err++; $display("FAIL tx_grant got %0d (expired=%0b) want 1", gid, to); end
      n_vec++; if (n_tx !== 1 || n_rx !== 0) begin n_err++; $display("FAIL tx_starts got tx=%0d rx=%0d want 1/0", n_tx, n_rx); end
      n_vec++; if (rv !== 4'b0010 || rc !== 6 || re !== 1'b0) begin n_err++; $display("FAIL tx_rsp got %b at %0d err %0b want 0010 at 6 err 0", rv, rc, re); end
      n_vec++; if (sb !== 0) begin n_err++; $display("FAIL tx_data_stable got %0d bad cycles want 0", sb); end
      n_vec++; if (rsp_rdata !== pat_a5) begin n_err++; $display("FAIL tx_rdata_hold got %h want a5 pattern", rsp_rdata[31:0]); end
      req_write = 4'b0000;
   endtask

   task automatic test_error();
      int gid, n_rx, n_tx, n_rsp, rc, sb; logic [NREQ-1:0] rv; logic re; bit to;
      req_valid = 4'b1000;
      run_xfer(1'b0, 6, 3, pat_5a, exp_addr[3], exp_wd[3], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
      n_vec++; if (to !== 1'b0 || gid !== 3 || rv !== 4'b1000) begin n_err++; $display("FAIL err_grant got %0d/%b want 3/1000", gid, rv); end
      n_vec++; if (re !== 1'b1 || rc !== 7) begin n_err++; $display("FAIL err_flag got %0b at %0d want 1 at 7", re, rc); end
      n_vec++; if (rsp_rdata !== pat_5a) begin n_err++; $display("FAIL err_rdata got %h want 5a pattern", rsp_rdata[31:0]); end
      req_valid = 4'b1000;
      run_xfer(1'b0, 4, -1, pat_5a, exp_addr[3], exp_wd[3], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
      n_vec++; if (to !== 1'b0 || re !== 1'b0 || rc !== 5) begin n_err++; $display("FAIL err_clear got %0b at %0d want 0 at 5", re, rc); end
   endtask

   task automatic test_timeout();
      int gid, n_rx, n_tx, n_rsp, rc, sb; logic [NREQ-1:0] rv; logic re; bit to;
      req_valid = 4'b0001;
      run_xfer(1'b0, -1, -1, pat_c3, exp_addr[0], exp_wd[0], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
      n_vec++; if (to !== 1'b0 || n_rsp !== 1 || rv !== 4'b0001) begin n_err++; $display("FAIL tmo_rsp got n=%0d vec=%b want 1/0001", n_rsp, rv); end
      n_vec++; if (rc !== 16 || re !== 1'b1) begin n_err++; $display("FAIL tmo_latency got %0d err %0b want 16 err 1", rc, re); end
      n_vec++; if (rsp_rdata !== pat_5a) begin n_err++; $display("FAIL tmo_rdata_hold got %h want 5a pattern", rsp_rdata[31:0]); end
      req_valid = 4'b0001;
      run_xfer(1'b0, 15, -1, pat_c3, exp_addr[0], exp_wd[0], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
      n_vec++; if (to !== 1'b0 || rc !== 16 || re !== 1'b0) begin n_err++; $display("FAIL tmo_done_wins got %0d err %0b want 16 err 0", rc, re); end
      n_vec++; if (rsp_rdata !== pat_c3) begin n_err++; $display("FAIL tmo_done_rdata got %h want c3 pattern", rsp_rdata[31:0]); end
   endtask

   task automatic test_reset_mid();
      int gid, n_rx, n_tx, n_rsp, rc, sb; logic [NREQ-1:0] rv; logic re; bit to;
      bit seen;
      seen = 1'b0;
      req_valid = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (dma_rx_start) begin seen = 1'b1; break; end
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL rstmid_start got none want rx_start"); end
      dma_idle = 1'b0;
      req_valid = 4'b0000;
      cyc(); cyc(); cyc();
      #3;
      rst = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %0b want 0", busy); end
      n_vec++; if (dma_rx_start !== 1'b0 || dma_tx_start !== 1'b0 || rsp_valid !== 4'b0000) begin
         n_err++; $display("FAIL rstmid_outputs got %b%b/%b want 00/0000", dma_rx_start, dma_tx_start, rsp_valid); end
      n_vec++; if (cur_id !== 2'd0 || dma_rx_address !== 32'h0) begin n_err++; $display("FAIL rstmid_latch got id %0d addr %h want 0/0", cur_id, dma_rx_address); end
      cyc();
      rst = 1'b0;
      dma_idle = 1'b1;
      req_valid = 4'b1011;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_ready got %b want 0001", req_ready); end
      run_xfer(1'b0, 3, -1, pat_c3, exp_addr[0], exp_wd[0], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
      n_vec++; if (to !== 1'b0 || gid !== 0) begin n_err++; $display("FAIL rstmid_next_grant got %0d want 0", gid); end
   endtask

   task automatic test_fairness();
      int gid, n_rx, n_tx, n_rsp, rc, sb; logic [NREQ-1:0] rv; logic re; bit to;
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         run_xfer(1'b1, 2, -1, pat_a5, exp_addr[i % 4], exp_wd[i % 4], gid, n_rx, n_tx, n_rsp, rc, rv, re, sb, to);
         n_vec++;
         if (to !== 1'b0 || gid !== (i % 4) || sb !== 0 || n_rsp !== 1) begin
            n_err++;
            $display("FAIL fair_order[%0d] got %0d (bad=%0d rsp=%0d) want %0d", i, gid, sb, n_rsp, i % 4);
         end
      end
      req_valid = 4'b0000;
      cyc();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_idle got %0b want 0", busy); end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      dma_rx_data = '0; dma_done = 1'b0; dma_idle = 1'b1; dma_error = 1'b0;
      pat_a5 = {128{8'hA5}};
      pat_5a = {128{8'h5A}};
      pat_c3 = {128{8'hC3}};
      exp_addr[0] = 32'h0000_0100; exp_addr[1] = 32'h2000_0040;
      exp_addr[2] = 32'h0000_1000; exp_addr[3] = 32'h3000_0000;
      exp_wd[0] = DATA_W'(32'h1111); exp_wd[1] = DATA_W'(32'h1234);
      exp_wd[2] = DATA_W'(32'h2222); exp_wd[3] = DATA_W'(32'h3333);
      for (int i = 0; i < NREQ; i++) begin
         req_addr[32*i +: 32]          = exp_addr[i];
         req_wdata[DATA_W*i +: DATA_W] = exp_wd[i];
      end
      test_reset();
      test_single_rx();
      test_tx();
      test_error();
      test_timeout();
      test_reset_mid();
      test_fairness();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dma_scheduler.md
DMA_SCHEDULER -- requirements
Module: dma_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the DMA port.
REQ-002 Parameter DATA_W, default 1024, DMA data width in bits.
REQ-003 Parameter TIMEOUT, default 4096, cycles allowed per transfer before abort; counter 16 bits wide.
REQ-004 The port list SHALL be as follows, clock and reset first:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester transfer request; held until granted.
- req_write  in  NREQ  1 = TX (FPGA to memory), 0 = RX.
- req_addr  in  NREQ*32  per-requester DMA address; slice i at [32i+31:32i].
- req_wdata  in  NREQ*DATA_W  per-requester TX data.
- req_ready  out  NREQ  one-hot grant, combinational, only in S_IDLE.
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- rsp_error  out  1  qualifies rsp_valid; 1 = DMA error or timeout.
- rsp_rdata  out  DATA_W  last RX data; holds until the next RX completion.
- dma_rx_address, dma_tx_address  out  32  both driven from the latched address.
- dma_tx_data  out  DATA_W  latched write data.
- dma_rx_start, dma_tx_start  out  1  start requests to the DMA engine.
- dma_rx_data  in  DATA_W; dma_done, dma_idle, dma_error  in  1  DMA engine status.
- busy  out  1  high in any state other than S_IDLE.
- cur_id  out  $clog2(NREQ)  index of the granted requester.

Function
REQ-005 The FSM SHALL have four states: S_IDLE, S_START, S_WAIT_DONE and S_RESP.
REQ-006 S_IDLE: if any req_valid is high, select one requester round-robin from pointer ptr, assert its req_ready, latch its addr, wdata, write flag and id, then go to S_START.
REQ-007 Round-robin: the first valid requester at or after ptr wins, wrapping from NREQ-1 to 0; on grant, ptr becomes (winner+1) mod NREQ.
REQ-008 S_START: assert dma_tx_start (write) or dma_rx_start (read) every cycle; go to S_WAIT_DONE in the first cycle dma_idle==0.
REQ-009 S_WAIT_DONE: on dma_done, capture dma_rx_data into rsp_rdata (reads only) and go to S_RESP.
REQ-010 S_RESP: pulse rsp_valid[cur_id] for exactly one cycle, then return to S_IDLE.
REQ-011 Timeout counter: cleared on S_IDLE to S_START and incremented in S_START and S_WAIT_DONE.
REQ-012 If the timeout counter reaches TIMEOUT-1 without dma_done, the FSM SHALL go to S_RESP with the error flag set.
REQ-013 dma_error sampled high in S_START or S_WAIT_DONE SHALL set a sticky per-transfer error flag; rsp_error equals this flag during S_RESP.
REQ-014 If dma_done and the timeout occur in the same cycle, done wins; error reflects only dma_error.
REQ-015 Latency: the start signal is asserted in the cycle after the grant; rsp_valid is asserted in the cycle after dma_done.
REQ-016 req_valid raised while busy SHALL be ignored until S_IDLE; no request is lost or double-granted.
REQ-017 A requester dropping req_valid before its grant SHALL have no effect.
REQ-018 Latched address and data SHALL remain stable from S_START through S_RESP.
REQ-019 Start signals SHALL be low outside S_START; the unused-direction start SHALL never assert.

Reset
REQ-020 rst SHALL force, asynchronously and at any time including mid-transfer:
- state to S_IDLE;
- ptr, cur_id, counter and error flag to 0;
- all start, ready and rsp outputs to 0;
- rsp_rdata and latched data/addresses to 0.

Structure
REQ-021 State encoding, ADDR_W=32 and the DATA_W default SHALL live in shared package rsa_pkg.
REQ-022 Round-robin selection SHALL be sub-module rr_arbiter (inputs: request vector, ptr; outputs: one-hot grant, index, any).

Verification
REQ-023 Single RX: req_valid[2]=1, read, addr 0x1000; dma_idle drops 1 cycle after start; dma_done 10 cycles later with data 0xA5..A5 -> rx_start for 1 cycle, rsp_valid[2] pulses once, rsp_rdata=0xA5..A5, rsp_error=0.
REQ-024 Fairness: all four req_valid held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-025 Timeout: TIMEOUT=16, dma_done never asserted -> rsp_valid with rsp_error=1 exactly 16 cycles after entering S_START.
REQ-026 Error: dma_error pulsed mid S_WAIT_DONE, then dma_done -> rsp_error=1; next transfer reports rsp_error=0.
REQ-027 Reset mid-transfer: rst in S_WAIT_DONE -> state S_IDLE, busy=0, starts=0, next grant goes to requester 0.
REQ-028 TX path: req_write[1]=1, wdata 0x1234 -> dma_tx_data=0x1234 and dma_tx_address stable until rsp_valid[1]; dma_rx_start stays 0.
